psu_on_seq_ctrl: RTL and testbench
==================================

PSU_ON_SEQ_CTRL -- requirements
Module: psu_on_seq_ctrl

Interface
REQ-001 SHALL have ports iClk (in, 1, 2 MHz reference clock) and iRst_n (in, 1, reset, asynchronous, active-low).
REQ-002 SHALL have iPwrReq (in, 1): power-on request; 1 = PSU on requested.
REQ-003 SHALL have iPsuPwrgd (in, 1): PSU power-good, already synchronized to iClk.
REQ-004 SHALL have iTmrDone (in, 1): done pulse from the external 2 MHz timer.
REQ-005 SHALL have oTmrEn (out, 1): external timer enable; low clears the timer count.
REQ-006 SHALL have oTmrSel (out, 1): timer period select; 1 = 50 ms, 0 = 1 s.
REQ-007 SHALL have oPsuOn (out, 1): PSU_ON drive; 1 = PSU enabled.
REQ-008 SHALL have oPwrOk (out, 1): PSU rail good and stable.
REQ-009 SHALL have oFault (out, 1): sequencing fault.
REQ-010 SHALL have oState (out, 3): current state encoding.
REQ-011 SHALL have oRetryCnt (out, 2): retries consumed.

Function
REQ-012 SHALL implement a Moore FSM with all outputs registered; states are IDLE=0, ON_WAIT=1, DEBOUNCE=2, PWR_ON=3, OFF=4, FAULT=5; codes 6-7 SHALL return to IDLE on the next clock.
REQ-013 IDLE: oPsuOn=0, oTmrEn=0; iPwrReq=1 -> ON_WAIT.
REQ-014 ON_WAIT: oPsuOn=1, oTmrSel=0 (1 s); iPsuPwrgd=1 -> DEBOUNCE; else iTmrDone -> FAULT; else iPwrReq=0 -> OFF.
REQ-015 DEBOUNCE: oPsuOn=1, oTmrSel=1 (50 ms); iPsuPwrgd=0 -> FAULT; else iTmrDone -> PWR_ON; else iPwrReq=0 -> OFF.
REQ-016 PWR_ON: oPsuOn=1, oPwrOk=1, oTmrEn=0, retry count cleared; iPsuPwrgd=0 -> FAULT; else iPwrReq=0 -> OFF.
REQ-017 OFF: oPsuOn=0, oTmrSel=1 (50 ms discharge); iTmrDone -> IDLE; iPwrReq is ignored until IDLE is reached.
REQ-018 FAULT: oPsuOn=0, oPwrOk=0, oFault=1; exits are defined in REQ-027 and REQ-028.
REQ-019 Priority within a state when events coincide SHALL be the listed order: power-good event first, then iTmrDone, then iPwrReq.
REQ-020 oTmrEn SHALL be 0 on the first clock of every timed state (ON_WAIT, DEBOUNCE, OFF, and FAULT when retry is enabled) and 1 thereafter, so the timer restarts from zero on each entry.
REQ-021 iTmrDone SHALL be ignored while oTmrEn=0 and in all untimed states.
REQ-022 Latency: an input sampled at edge N SHALL be reflected in the state and outputs at edge N+1.
REQ-023 oState SHALL equal the state register; oRetryCnt SHALL saturate at 3.

Reset
REQ-024 While iRst_n=0, state SHALL be IDLE, all outputs 0, and the retry count 0, independent of iClk.
REQ-025 Reset asserted mid-sequence SHALL drop oPsuOn immediately, with no OFF discharge phase.
REQ-026 After reset release, the first transition SHALL occur no earlier than the first iClk rising edge with iRst_n=1.

Configuration
REQ-027 Without PSU_AUTO_RETRY_EN: FAULT is latched, oTmrEn=0, and iPwrReq=0 -> IDLE (clears oFault); oRetryCnt stays 0.
REQ-028 With PSU_AUTO_RETRY_EN: FAULT runs a 1 s timer (oTmrSel=0); on iTmrDone, if iPwrReq=1 and retry count <3, the count increments and the FSM goes to ON_WAIT; if the count =3, FAULT stays latched with the timer off; iPwrReq=0 -> IDLE and clears the count.

Verification
REQ-029 Nominal: iPwrReq=1; iPsuPwrgd=1 after 1000 cycles; iTmrDone pulses 100001 cycles after DEBOUNCE entry -> oPwrOk=1 one cycle later, oState=3.
REQ-030 Timeout: iPwrReq=1, iPsuPwrgd held 0, iTmrDone pulses in ON_WAIT -> oFault=1, oPsuOn=0 next cycle; drop iPwrReq -> IDLE.
REQ-031 Glitch: iPsuPwrgd drops for 1 cycle during DEBOUNCE -> FAULT; iPsuPwrgd drop in PWR_ON -> FAULT, oPwrOk=0 next cycle.
REQ-032 Coincidence: iPsuPwrgd=1 and iTmrDone=1 on the same ON_WAIT cycle -> DEBOUNCE (not FAULT); oTmrEn=0 for exactly one cycle on entry.
REQ-033 Retry (macro defined): PSU never good -> three ON_WAIT re-entries, oRetryCnt 1,2,3, then latched FAULT; without the macro -> single FAULT, oRetryCnt=0.
REQ-034 Reset in PWR_ON: iRst_n=0 -> oPsuOn=0 and oState=0 asynchronously, before the next iClk edge.

Source files
------------

// File: rtl/psu_on_seq_ctrl.sv
// PSU power-on sequencer: registered Moore FSM driving PSU_ON and an external timer.
// Define PSU_AUTO_RETRY_EN to let FAULT retry up to three times on a 1 s backoff.
module psu_on_seq_ctrl (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iPwrReq,
  input  logic       iPsuPwrgd,
  input  logic       iTmrDone,
  output logic       oTmrEn,
  output logic       oTmrSel,
  output logic       oPsuOn,
  output logic       oPwrOk,
  output logic       oFault,
  output logic [2:0] oState,
  output logic [1:0] oRetryCnt
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StOnWait   = 3'd1,
    StDebounce = 3'd2,
    StPwrOn    = 3'd3,
    StOff      = 3'd4,
    StFault    = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       tmr_en_d, tmr_sel_d, psu_on_d, pwr_ok_d, fault_d;
  logic       done;
  logic       stay;

  // A done pulse only counts once the timer has been running for a cycle.
  assign done = iTmrDone & oTmrEn;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (iPwrReq) state_d = StOnWait;
      end
      StOnWait: begin
        if (iPsuPwrgd)     state_d = StDebounce;
        else if (done)     state_d = StFault;
        else if (!iPwrReq) state_d = StOff;
      end
      StDebounce: begin
        if (!iPsuPwrgd)    state_d = StFault;
        else if (done)     state_d = StPwrOn;
        else if (!iPwrReq) state_d = StOff;
      end
      StPwrOn: begin
        if (!iPsuPwrgd)    state_d = StFault;
        else if (!iPwrReq) state_d = StOff;
      end
      StOff: begin
        if (done) state_d = StIdle;
      end
      StFault: begin
`ifdef PSU_AUTO_RETRY_EN
        if (done && iPwrReq && (cnt_q != 2'd3)) begin
          state_d = StOnWait;
          cnt_d   = cnt_q + 2'd1;
        end else if (!iPwrReq) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
`else
        if (!iPwrReq) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StPwrOn) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    stay      = (state_d == state_q);
    tmr_en_d  = 1'b0;
    tmr_sel_d = (state_d == StDebounce) || (state_d == StOff);
    psu_on_d  = (state_d == StOnWait) || (state_d == StDebounce) || (state_d == StPwrOn);
    pwr_ok_d  = (state_d == StPwrOn);
    fault_d   = (state_d == StFault);
    case (state_d)
      StOnWait, StDebounce, StOff: tmr_en_d = stay;
`ifdef PSU_AUTO_RETRY_EN
      StFault: tmr_en_d = stay && (cnt_d != 2'd3);
`endif
      default: tmr_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      oTmrEn  <= 1'b0;
      oTmrSel <= 1'b0;
      oPsuOn  <= 1'b0;
      oPwrOk  <= 1'b0;
      oFault  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oTmrEn  <= tmr_en_d;
      oTmrSel <= tmr_sel_d;
      oPsuOn  <= psu_on_d;
      oPwrOk  <= pwr_ok_d;
      oFault  <= fault_d;
    end
  end

  assign oState    = state_q;
  assign oRetryCnt = cnt_q;

endmodule

// File: tb/tb_psu_on_seq_ctrl.sv
// Randomised and directed bench for psu_on_seq_ctrl against a behavioural reference model.
`timescale 1ns/1ps
module tb_psu_on_seq_ctrl;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b1;
  logic       iPwrReq = 1'b0;
  logic       iPsuPwrgd = 1'b0;
  logic       iTmrDone = 1'b0;
  logic       oTmrEn, oTmrSel, oPsuOn, oPwrOk, oFault;
  logic [2:0] oState;
  logic [1:0] oRetryCnt;
  logic [9:0] outs;

  int errors = 0;
  int checks = 0;

`ifdef PSU_AUTO_RETRY_EN
  localparam bit Retry = 1'b1;
`else
  localparam bit Retry = 1'b0;
`endif

  psu_on_seq_ctrl dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iPwrReq   (iPwrReq),
    .iPsuPwrgd (iPsuPwrgd),
    .iTmrDone  (iTmrDone),
    .oTmrEn    (oTmrEn),
    .oTmrSel   (oTmrSel),
    .oPsuOn    (oPsuOn),
    .oPwrOk    (oPwrOk),
    .oFault    (oFault),
    .oState    (oState),
    .oRetryCnt (oRetryCnt)
  );

  always #250 iClk = ~iClk;

  assign outs = {oState, oRetryCnt, oFault, oPwrOk, oPsuOn, oTmrSel, oTmrEn};

  // Reference model: state number, cycles spent in it, retries consumed.
  int m_state = 0;
  int m_age   = 0;
  int m_cnt   = 0;

  function automatic logic [9:0] m_exp();
    logic en, timed;
    timed = (m_state == 1) || (m_state == 2) || (m_state == 4) ||
            (Retry && m_state == 5 && m_cnt < 3);
    en = timed && (m_age > 0);
    return {3'(m_state), 2'(m_cnt), m_state == 5, m_state == 3,
            (m_state >= 1 && m_state <= 3), (m_state == 2 || m_state == 4), en};
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_age   = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_step(input bit req, input bit pg, input bit done);
    logic [9:0] e;
    bit dv;
    int ns;
    e  = m_exp();
    dv = done && e[0];
    ns = m_state;
    case (m_state)
      0: if (req) ns = 1;
      1: if (pg) ns = 2; else if (dv) ns = 5; else if (!req) ns = 4;
      2: if (!pg) ns = 5; else if (dv) ns = 3; else if (!req) ns = 4;
      3: if (!pg) ns = 5; else if (!req) ns = 4;
      4: if (dv) ns = 0;
      5: begin
        if (Retry && dv && req && m_cnt < 3) begin
          ns = 1;
          m_cnt++;
        end else if (!req) begin
          ns = 0;
          m_cnt = 0;
        end
      end
      default: ns = 0;
    endcase
    if (ns == 3) m_cnt = 0;
    m_age   = (ns == m_state) ? m_age + 1 : 0;
    m_state = ns;
  endfunction

  task automatic drive(input bit req, input bit pg, input bit done);
    iPwrReq   = req;
    iPsuPwrgd = pg;
    iTmrDone  = done;
    @(posedge iClk);
    model_step(req, pg, done);
    #1;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 20 && m_state != 0; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #5 iRst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (outs !== 10'd0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", outs, 10'd0);
    end
    iPwrReq = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    checks++;
    if (outs !== m_exp()) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", outs, m_exp());
    end
    iRst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== m_exp()) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", outs, m_exp());
    end
  endtask

  task automatic test_nominal();
    go_idle();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (outs !== m_exp()) begin
        errors++;
        $display("FAIL nominal_onwait cyc=%0d got=%h exp=%h", i, outs, m_exp());
      end
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (outs !== m_exp()) begin
        errors++;
        $display("FAIL nominal_debounce cyc=%0d got=%h exp=%h", i, outs, m_exp());
      end
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (oPwrOk !== 1'b1 || oState !== 3'd3 || outs !== m_exp()) begin
      errors++;
      $display("FAIL nominal_pwron got=%h exp=%h", outs, m_exp());
    end
  endtask

  task automatic test_timeout();
    go_idle();
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (oFault !== 1'b1 || oPsuOn !== 1'b0 || oState !== 3'd5 || outs !== m_exp()) begin
      errors++;
      $display("FAIL timeout_fault got=%h exp=%h", outs, m_exp());
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (oState !== 3'd0 || oFault !== 1'b0 || outs !== m_exp()) begin
      errors++;
      $display("FAIL timeout_idle got=%h exp=%h", outs, m_exp());
    end
  endtask

  task automatic test_glitch();
    go_idle();
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (oState !== 3'd5 || outs !== m_exp()) begin
      errors++;
      $display("FAIL glitch_debounce got=%h exp=%h", outs, m_exp());
    end
    go_idle();
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (oPwrOk !== 1'b1) begin
      errors++;
      $display("FAIL glitch_reach_pwron got=%b exp=1", oPwrOk);
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (oPwrOk !== 1'b0 || oState !== 3'd5 || outs !== m_exp()) begin
      errors++;
      $display("FAIL glitch_pwron got=%h exp=%h", outs, m_exp());
    end
  endtask

  task automatic test_coincidence();
    go_idle();
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (oState !== 3'd2 || oTmrEn !== 1'b0 || outs !== m_exp()) begin
      errors++;
      $display("FAIL coinc_entry got=%h exp=%h", outs, m_exp());
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (oTmrEn !== 1'b1 || oTmrSel !== 1'b1 || outs !== m_exp()) begin
      errors++;
      $display("FAIL coinc_second got=%h exp=%h", outs, m_exp());
    end
  endtask

  task automatic test_retry();
    go_idle();
    drive(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      repeat (2) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      checks++;
      if (oState !== 3'd5 || outs !== m_exp()) begin
        errors++;
        $display("FAIL retry_fault r=%0d got=%h exp=%h", r, outs, m_exp());
      end
      repeat (2) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      checks++;
      if (Retry && r < 3) begin
        if (oState !== 3'd1 || oRetryCnt !== 2'(r + 1) || outs !== m_exp()) begin
          errors++;
          $display("FAIL retry_reenter r=%0d got=%h exp=%h", r, outs, m_exp());
        end
      end else begin
        if (oState !== 3'd5 || oTmrEn !== 1'b0 || outs !== m_exp()) begin
          errors++;
          $display("FAIL retry_latched r=%0d got=%h exp=%h", r, outs, m_exp());
        end
      end
      if (m_state == 5) break;
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (oState !== 3'd0 || oRetryCnt !== 2'd0 || outs !== m_exp()) begin
      errors++;
      $display("FAIL retry_clear got=%h exp=%h", outs, m_exp());
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    #100 iRst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (oPsuOn !== 1'b0 || oState !== 3'd0 || outs !== 10'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", outs, 10'd0);
    end
    @(posedge iClk);
    #1 iRst_n = 1'b1;
  endtask

  task automatic test_random();
    bit req = 1'b1;
    bit pg  = 1'b0;
    bit done;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) req = ~req;
      if ($urandom_range(0, 7) == 0) pg = ~pg;
      done = ($urandom_range(0, 3) == 0);
      drive(req, pg, done);
      checks++;
      if (outs !== m_exp()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, outs, m_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_glitch();
    test_coincidence();
    test_retry();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
